// File: rtl/gmii_tx_buffer_pkg.sv
`default_nettype none
// ============================================================================
//  Package : gmii_tx_buffer_pkg
//  Brief   : Shared GMII constants and read-side FSM encoding for the
//            store-and-forward GMII transmit buffer.
//  Rev     : 1.0  initial release
// ============================================================================
package gmii_tx_buffer_pkg;

  // Minimum idle clocks forced after every transmitted frame
  localparam int GMII_IFG_BYTES = 12;

  // Frame delimiters, inserted upstream by the MAC
  localparam logic [7:0] GMII_PREAMBLE = 8'h55;
  localparam logic [7:0] GMII_SFD      = 8'hD5;

  // Read-side FSM encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_SEND  = 2'd2;
  localparam logic [1:0] ST_GAP   = 2'd3;

  typedef enum logic [1:0] {
    TX_IDLE  = ST_IDLE,
    TX_FETCH = ST_FETCH,
    TX_SEND  = ST_SEND,
    TX_GAP   = ST_GAP
  } tx_state_t;

endpackage
`default_nettype wire

// File: rtl/tx_buf_dpram.sv
`default_nettype none
// ============================================================================
//  Module : tx_buf_dpram
//  Brief  : Simple dual-port byte RAM, one write port and one read port with
//           a registered output (one clock read latency).
//  Rev    : 1.0  initial release
// ============================================================================
module tx_buf_dpram #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Write port plus registered read; contents carry no reset
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

endmodule
`default_nettype wire

// File: rtl/gmii_tx_buffer.sv
`default_nettype none
// ============================================================================
//  Module : gmii_tx_buffer
//  Brief  : Store-and-forward frame buffer between the MAC TX byte stream and
//           the GMII TX pins. Complete frames are committed, then replayed as
//           one back-to-back burst followed by a forced inter-frame gap.
//           Frames that overflow the byte RAM or the length FIFO are dropped.
//  Rev    : 1.0  initial release
// ============================================================================
module gmii_tx_buffer
  import gmii_tx_buffer_pkg::*;
#(
  parameter int ADDR_W    = 11,
  parameter int LEN_AW    = 3,
  parameter int IFG_BYTES = GMII_IFG_BYTES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        mac_tx_data,
  input  logic              mac_data_valid,
  input  logic              mac_send_end,
  output logic [7:0]        gmii_txd,
  output logic              gmii_tx_en,
  output logic              gmii_tx_er,
  output logic              frame_drop,
  output logic [LEN_AW:0]   frames_pending
);

  localparam int PW        = ADDR_W + 1;
  localparam int LEN_DEPTH = 2**LEN_AW;
  localparam logic [PW-1:0]   BUF_BYTES = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [LEN_AW:0] LEN_SLOTS = {1'b1, {LEN_AW{1'b0}}};
  localparam logic [7:0]      GAP_LOAD  = 8'(IFG_BYTES - 1);

  // Write side state
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   commit_ptr;
  logic [PW-1:0]   frame_len;
  logic            frame_bad;

  // Length FIFO
  logic [PW-1:0]   len_mem [LEN_DEPTH];
  logic [LEN_AW:0] len_wr;
  logic [LEN_AW:0] len_rd;

  // Read side state
  tx_state_t       state;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   tx_cnt;
  logic [7:0]      gap_cnt;
  logic [7:0]      ram_q;

  // Combinational helpers
  logic            buf_full;
  logic            byte_write;
  logic            bad_now;
  logic [PW-1:0]   len_now;
  logic [PW-1:0]   wr_ptr_inc;
  logic            len_full;
  logic            len_empty;
  logic            do_commit;
  logic            do_drop;
  logic            tx_last;

  assign gmii_tx_er = 1'b0;

  // Occupancy is judged against rd_ptr so space frees up as bytes go out.
  // A byte landing in the same cycle as mac_send_end belongs to the frame,
  // so the end-of-frame decision uses the post-byte length and bad flag.
  always_comb begin
    buf_full   = (wr_ptr - rd_ptr) == BUF_BYTES;
    byte_write = mac_data_valid && !frame_bad && !buf_full;
    bad_now    = frame_bad || (mac_data_valid && buf_full);
    len_now    = frame_len + PW'(byte_write);
    wr_ptr_inc = wr_ptr + PW'(byte_write);
    len_full   = (len_wr - len_rd) == LEN_SLOTS;
    len_empty  = (len_wr == len_rd);
    do_commit  = mac_send_end && !bad_now && (len_now != '0) && !len_full;
    do_drop    = mac_send_end && (bad_now || ((len_now != '0) && len_full));
    tx_last    = (state == TX_SEND) && (tx_cnt == PW'(1));
  end

  tx_buf_dpram #(
    .ADDR_W (ADDR_W),
    .DATA_W (8)
  ) u_ram (
    .clk     (clk),
    .we      (byte_write),
    .wr_addr (wr_ptr[ADDR_W-1:0]),
    .wr_data (mac_tx_data),
    .rd_addr (rd_ptr[ADDR_W-1:0]),
    .rd_data (ram_q)
  );

  // Write pointer, frame accounting, commit/rollback and drop pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      commit_ptr <= '0;
      frame_len  <= '0;
      frame_bad  <= 1'b0;
      frame_drop <= 1'b0;
      len_wr     <= '0;
    end else begin
      frame_drop <= do_drop;
      if (mac_send_end) begin
        frame_len <= '0;
        frame_bad <= 1'b0;
        if (do_commit) begin
          wr_ptr     <= wr_ptr_inc;
          commit_ptr <= wr_ptr_inc;
          len_wr     <= len_wr + 1'b1;
        end else if (do_drop) begin
          wr_ptr <= commit_ptr;
        end else begin
          wr_ptr <= wr_ptr_inc;
        end
      end else begin
        wr_ptr    <= wr_ptr_inc;
        frame_len <= len_now;
        frame_bad <= bad_now;
      end
    end
  end

  // Length FIFO storage; validity is tracked by the pointers alone
  always_ff @(posedge clk) begin
    if (do_commit) begin
      len_mem[len_wr[LEN_AW-1:0]] <= len_now;
    end
  end

  // Committed-but-unsent frame count; simultaneous commit and finish cancel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frames_pending <= '0;
    end else begin
      case ({do_commit, tx_last})
        2'b10:   frames_pending <= frames_pending + 1'b1;
        2'b01:   frames_pending <= frames_pending - 1'b1;
        default: frames_pending <= frames_pending;
      endcase
    end
  end

  // Replay FSM: pop length, prime the RAM read, stream bytes, hold the gap.
  // rd_ptr runs one byte ahead of the output to hide the RAM latency, so it
  // is not advanced on the final byte of a frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= TX_IDLE;
      rd_ptr     <= '0;
      len_rd     <= '0;
      tx_cnt     <= '0;
      gap_cnt    <= '0;
      gmii_txd   <= 8'h00;
      gmii_tx_en <= 1'b0;
    end else begin
      case (state)
        TX_IDLE: begin
          gmii_txd   <= 8'h00;
          gmii_tx_en <= 1'b0;
          if (!len_empty) begin
            tx_cnt <= len_mem[len_rd[LEN_AW-1:0]];
            len_rd <= len_rd + 1'b1;
            state  <= TX_FETCH;
          end
        end
        TX_FETCH: begin
          gmii_txd   <= 8'h00;
          gmii_tx_en <= 1'b0;
          rd_ptr     <= rd_ptr + PW'(1);
          state      <= TX_SEND;
        end
        TX_SEND: begin
          gmii_txd   <= ram_q;
          gmii_tx_en <= 1'b1;
          tx_cnt     <= tx_cnt - PW'(1);
          if (tx_cnt == PW'(1)) begin
            gap_cnt <= GAP_LOAD;
            state   <= TX_GAP;
          end else begin
            rd_ptr <= rd_ptr + PW'(1);
          end
        end
        TX_GAP: begin
          gmii_txd   <= 8'h00;
          gmii_tx_en <= 1'b0;
          if (gap_cnt == 8'd0) begin
            state <= TX_IDLE;
          end else begin
            gap_cnt <= gap_cnt - 8'd1;
          end
        end
        default: begin
          gmii_txd   <= 8'h00;
          gmii_tx_en <= 1'b0;
          state      <= TX_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
